// File: rtl/spi_slave_if.sv
// spi_slave_if: signal bundle between an SPI slave endpoint and its environment.
//   ss_n, MOSI         serial link from the SPI master
//   MISO, valid_MISO   serial reply to the SPI master
//   sready             slave idle and free for a new frame
//   rx_data, rx_valid  received frame and its 1-cycle strobe
//   tx_data, tx_valid  reply word offered by the local logic
// Modports: slave (the endpoint) and master (the environment driving it).
interface spi_slave_if #(
    parameter int RX_W = 10,
    parameter int TX_W = 8
);
    logic            ss_n;
    logic            MOSI;
    logic            MISO;
    logic            valid_MISO;
    logic            sready;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic [TX_W-1:0] tx_data;
    logic            tx_valid;

    modport slave (
        input  ss_n, MOSI, tx_data, tx_valid,
        output MISO, valid_MISO, sready, rx_data, rx_valid
    );

    modport master (
        output ss_n, MOSI, tx_data, tx_valid,
        input  MISO, valid_MISO, sready, rx_data, rx_valid
    );
endinterface

// File: rtl/spi_slave.sv
// spi_slave: SPI slave endpoint. Deserialises an RX_W-bit MOSI frame (MSB
// first) into rx_data with a 1-cycle rx_valid. When the two top bits of the
// frame equal CMD_READ it waits for tx_valid, then serialises the TX_W-bit
// reply on MISO (MSB first) qualified by valid_MISO.
// Ports:
//   clk    in  SPI bit clock, all state updates on posedge
//   rst_n  in  synchronous reset, active-low
//   bus    slave modport of spi_slave_if (ss_n, MOSI, MISO, valid_MISO,
//          sready, rx_data, rx_valid, tx_data, tx_valid)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | free; ss_n low starts a frame (no bit taken on that edge)
// S_RECV   | shifting in MOSI bits, MSB first
// S_WAIT_TX| read command received, waiting for tx_valid
// S_SEND   | driving reply bits on MISO
// S_HOLD   | frame finished, ignore MOSI until ss_n goes high
module spi_slave #(
    parameter int         RX_W     = 10,
    parameter int         TX_W     = 8,
    parameter logic [1:0] CMD_READ = 2'b11
) (
    input  logic      clk,
    input  logic      rst_n,
    spi_slave_if.slave bus
);

    localparam int CNT_W = $clog2((RX_W > TX_W) ? RX_W : TX_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WAIT_TX,
        S_SEND,
        S_HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Only RX_W-1 bits are stored; the last bit comes straight from MOSI.
    logic [RX_W-2:0]   shift_q, shift_d;
    logic [RX_W-1:0]   shift_nxt;
    logic [RX_W-1:0]   rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [TX_W-1:0]   tx_shift_q, tx_shift_d;
    logic              miso_q, miso_d;
    logic              valid_miso_q, valid_miso_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            valid_miso_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            valid_miso_q <= valid_miso_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        shift_nxt    = {shift_q, bus.MOSI};
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_shift_d   = tx_shift_q;
        miso_d       = miso_q;
        valid_miso_d = valid_miso_q;

        case (state_q)
            S_IDLE: begin
                if (!bus.ss_n) begin
                    state_d = S_RECV;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end

            S_RECV: begin
                if (bus.ss_n) begin
                    // Abort: partial frame is dropped, rx_data untouched.
                    state_d      = S_IDLE;
                    miso_d       = 1'b0;
                    valid_miso_d = 1'b0;
                end else begin
                    shift_d = shift_nxt[RX_W-2:0];
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(RX_W - 1)) begin
                        rx_data_d  = shift_nxt;
                        rx_valid_d = 1'b1;
                        if (shift_nxt[RX_W-1 -: 2] == CMD_READ) begin
                            state_d = S_WAIT_TX;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end
                end
            end

            S_WAIT_TX: begin
                if (bus.ss_n) begin
                    state_d      = S_IDLE;
                    miso_d       = 1'b0;
                    valid_miso_d = 1'b0;
                end else if (bus.tx_valid) begin
                    // MSB goes out on the accepting edge; the rest queue up.
                    state_d      = S_SEND;
                    cnt_d        = '0;
                    miso_d       = bus.tx_data[TX_W-1];
                    valid_miso_d = 1'b1;
                    tx_shift_d   = {bus.tx_data[TX_W-2:0], 1'b0};
                end
            end

            S_SEND: begin
                if (bus.ss_n) begin
                    state_d      = S_IDLE;
                    miso_d       = 1'b0;
                    valid_miso_d = 1'b0;
                end else if (cnt_q == CNT_W'(TX_W - 1)) begin
                    state_d      = S_HOLD;
                    miso_d       = 1'b0;
                    valid_miso_d = 1'b0;
                end else begin
                    miso_d     = tx_shift_q[TX_W-1];
                    tx_shift_d = {tx_shift_q[TX_W-2:0], 1'b0};
                    cnt_d      = cnt_q + CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (bus.ss_n) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d      = S_IDLE;
                miso_d       = 1'b0;
                valid_miso_d = 1'b0;
            end
        endcase
    end

    assign bus.MISO       = miso_q;
    assign bus.valid_MISO = valid_miso_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.sready     = (state_q == S_IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Testbench for spi_slave: directed scenarios followed by randomized frames,
// checked against expectations derived from the frame-level behaviour
// (frame value, command bits, reply word, reply delay).
module tb_spi_slave;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_slave_if #(.RX_W(10), .TX_W(8)) bus ();

    spi_slave #(.RX_W(10), .TX_W(8), .CMD_READ(2'b11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         total  = 0;
    int         bad    = 0;
    bit         inv_on = 1'b0;
    logic [9:0] exp_rx = '0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MISO must be low whenever valid_MISO is low.
    always @(negedge clk) begin
        if (inv_on) begin
            total++;
            assert (bus.valid_MISO === 1'b1 || bus.MISO === 1'b0) else begin
                bad++;
                $error("FAIL miso_invariant observed=%0b expected=0", bus.MISO);
            end
        end
    end

    // Starts a frame from IDLE and shifts in the first n bits of f, MSB first.
    task automatic shift_bits(input logic [9:0] f, input int n);
        bus.ss_n = 1'b0;
        bus.MOSI = 1'($urandom);
        tick;
        chk("sready_start", 32'(bus.sready), 0);
        for (int i = 0; i < n; i++) begin
            bus.MOSI = f[9-i];
            tick;
            if (i < 9) begin
                chk("rx_valid_early", 32'(bus.rx_valid), 0);
                chk("valid_miso_recv", 32'(bus.valid_MISO), 0);
            end
        end
    endtask

    // Full frame; for read commands the reply is offered dly cycles after rx_valid.
    task automatic run_frame(input logic [9:0] f, input logic [7:0] r, input int dly);
        shift_bits(f, 10);
        exp_rx = f;
        chk("rx_valid_pulse", 32'(bus.rx_valid), 1);
        chk("rx_data", 32'(bus.rx_data), 32'(exp_rx));
        chk("valid_miso_at_rx", 32'(bus.valid_MISO), 0);
        if (f[9:8] == 2'b11) begin
            for (int k = 0; k < dly; k++) begin
                bus.tx_valid = 1'b0;
                bus.MOSI     = 1'($urandom);
                tick;
                chk("rx_valid_one_cycle", 32'(bus.rx_valid), 0);
                chk("valid_miso_wait", 32'(bus.valid_MISO), 0);
                chk("sready_wait", 32'(bus.sready), 0);
            end
            bus.tx_valid = 1'b1;
            bus.tx_data  = r;
            tick;
            bus.tx_valid = 1'b0;
            bus.tx_data  = 8'($urandom);
            chk("rx_valid_after_accept", 32'(bus.rx_valid), 0);
            for (int b = 7; b >= 0; b--) begin
                chk("valid_miso_bit", 32'(bus.valid_MISO), 1);
                chk("miso_bit", 32'(bus.MISO), 32'(r[b]));
                bus.MOSI = 1'($urandom);
                tick;
            end
            chk("valid_miso_end", 32'(bus.valid_MISO), 0);
            chk("miso_end", 32'(bus.MISO), 0);
            chk("sready_hold", 32'(bus.sready), 0);
        end else begin
            for (int k = 0; k < 3; k++) begin
                bus.MOSI     = 1'($urandom);
                bus.tx_valid = 1'($urandom);
                bus.tx_data  = 8'($urandom);
                tick;
                chk("valid_miso_hold", 32'(bus.valid_MISO), 0);
                chk("rx_valid_hold", 32'(bus.rx_valid), 0);
                chk("sready_hold", 32'(bus.sready), 0);
            end
            bus.tx_valid = 1'b0;
        end
        bus.ss_n = 1'b1;
        tick;
        chk("sready_release", 32'(bus.sready), 1);
        chk("rx_data_held", 32'(bus.rx_data), 32'(exp_rx));
        chk("valid_miso_idle", 32'(bus.valid_MISO), 0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_miso"}, 32'(bus.MISO), 0);
        chk({tag, "_valid_miso"}, 32'(bus.valid_MISO), 0);
        chk({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
        chk({tag, "_rx_data"}, 32'(bus.rx_data), 0);
        chk({tag, "_sready"}, 32'(bus.sready), 1);
    endtask

    initial begin
        logic [9:0] f;
        logic [7:0] r;

        // Reset with ss_n low and MOSI high
        bus.ss_n     = 1'b0;
        bus.MOSI     = 1'b1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        rst_n        = 1'b0;
        tick;
        tick;
        chk_reset_values("reset");
        bus.ss_n = 1'b1;
        rst_n    = 1'b1;
        tick;
        inv_on = 1'b1;
        exp_rx = '0;
        chk("sready_after_reset", 32'(bus.sready), 1);

        // Write frame
        run_frame(10'h0A5, 8'h00, 0);

        // Read frame, reply two cycles after rx_valid
        run_frame(10'h3C4, 8'hB6, 2);

        // Abort in RECV after 5 bits
        shift_bits(10'h2AB, 5);
        bus.ss_n = 1'b1;
        tick;
        chk("abort_recv_rx_valid", 32'(bus.rx_valid), 0);
        chk("abort_recv_rx_data", 32'(bus.rx_data), 32'(exp_rx));
        chk("abort_recv_sready", 32'(bus.sready), 1);
        run_frame(10'h155, 8'h00, 0);

        // Abort in SEND after 3 reply bits
        r = 8'h5D;
        shift_bits(10'h35A, 10);
        exp_rx = 10'h35A;
        chk("send_abort_rx_data", 32'(bus.rx_data), 32'(exp_rx));
        bus.tx_valid = 1'b1;
        bus.tx_data  = r;
        tick;
        bus.tx_valid = 1'b0;
        for (int b = 7; b >= 5; b--) begin
            chk("send_abort_valid", 32'(bus.valid_MISO), 1);
            chk("send_abort_bit", 32'(bus.MISO), 32'(r[b]));
            if (b > 5) tick;
        end
        bus.ss_n = 1'b1;
        tick;
        chk("abort_send_valid", 32'(bus.valid_MISO), 0);
        chk("abort_send_miso", 32'(bus.MISO), 0);
        chk("abort_send_sready", 32'(bus.sready), 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
        tick;
        tick;
        bus.tx_valid = 1'b0;
        chk("stray_tx_valid", 32'(bus.valid_MISO), 0);
        chk("stray_tx_miso", 32'(bus.MISO), 0);
        chk("stray_tx_sready", 32'(bus.sready), 1);
        run_frame(10'h3E1, 8'h81, 1);

        // Reset during bit 6 of 10'h2FF
        shift_bits(10'h2FF, 5);
        bus.MOSI = 1'b1;
        rst_n    = 1'b0;
        tick;
        tick;
        chk_reset_values("midreset");
        exp_rx   = '0;
        rst_n    = 1'b1;
        bus.ss_n = 1'b1;
        tick;
        chk("sready_after_midreset", 32'(bus.sready), 1);
        run_frame(10'h001, 8'h00, 0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            f = 10'($urandom);
            if ($urandom_range(0, 1) == 1) f[9:8] = 2'b11;
            r = 8'($urandom);
            run_frame(f, r, int'($urandom_range(0, 3)));
        end

        inv_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
